// File: rtl/load_read_unit.sv
// load_read_unit: services one core load at a time. It issues a word-aligned
// read to data memory with a req/ack handshake, then extracts and extends the
// addressed byte, halfword or word into a held output register. Misaligned,
// illegal and timed-out loads complete with ld_err set and ld_data cleared.
module load_read_unit #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [2:0]            ld_funct3,
    output logic                  ld_busy,
    output logic                  ld_valid,
    output logic [WIDTH-1:0]      ld_data,
    output logic                  ld_err,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                  mem_rd_ack,
    input  logic [WIDTH-1:0]      mem_rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [1:0]              lane, lane_next;
    logic [2:0]              funct3, funct3_next;
    logic                    req_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [WIDTH-1:0]        data_next;
    logic                    err_next;

    // A request is rejected up front if funct3 is unused or the access
    // straddles its natural alignment.
    function automatic logic is_bad(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3)
            3'd0, 3'd4: bad = 1'b0;
            3'd1, 3'd5: bad = a[0];
            3'd2:       bad = (a != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend.
    // For aligned halfwords, shifting by lane equals shifting by 16*a[1].
    function automatic logic [WIDTH-1:0] extract(input logic [WIDTH-1:0] word,
                                                 input logic [1:0]       a,
                                                 input logic [2:0]       f3);
        logic [WIDTH-1:0] shifted;
        logic [WIDTH-1:0] res;
        shifted = word >> {a, 3'b000};
        case (f3)
            3'd0:    res = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'd4:    res = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            3'd1:    res = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'd5:    res = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    assign ld_busy  = (state != IDLE);
    assign ld_valid = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-register values; everything holds by default.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        lane_next   = lane;
        funct3_next = funct3;
        req_next    = mem_rd_req;
        addr_next   = mem_rd_addr;
        data_next   = ld_data;
        err_next    = ld_err;
        case (state)
            IDLE: begin
                if (ld_req) begin
                    lane_next   = ld_addr[1:0];
                    funct3_next = ld_funct3;
                    if (is_bad(ld_funct3, ld_addr[1:0])) begin
                        state_next = DONE;
                        data_next  = '0;
                        err_next   = 1'b1;
                    end else begin
                        state_next = REQ;
                        req_next   = 1'b1;
                        addr_next  = {ld_addr[ADDR_WIDTH-1:2], 2'b00};
                        cnt_next   = '0;
                    end
                end
            end
            REQ: begin
                // Ack takes priority over the timeout on the same edge.
                if (mem_rd_ack) begin
                    state_next = DONE;
                    req_next   = 1'b0;
                    data_next  = extract(mem_rd_data, lane, funct3);
                    err_next   = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_next = DONE;
                    req_next   = 1'b0;
                    data_next  = '0;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and handshake registers; reset clears every visible output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            lane        <= '0;
            funct3      <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
            ld_data     <= '0;
            ld_err      <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            lane        <= lane_next;
            funct3      <= funct3_next;
            mem_rd_req  <= req_next;
            mem_rd_addr <= addr_next;
            ld_data     <= data_next;
            ld_err      <= err_next;
        end
    end

endmodule

// File: tb/tb_load_read_unit.sv
// Testbench for load_read_unit: scenario tasks push expected results to a
// scoreboard queue, run a load against a scripted memory responder, then pop
// and compare.
module tb_load_read_unit;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [2:0]  ld_funct3 = '0;
    logic        ld_busy, ld_valid, ld_err, mem_rd_req;
    logic [31:0] ld_data, mem_rd_addr;
    logic        mem_rd_ack = 1'b0;
    logic [31:0] mem_rd_data = '0;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    exp_t ex;

    // Observations returned by run_load.
    int          o_lat, o_req;
    logic [31:0] o_raddr, o_d;
    logic        o_e, o_va, o_ba, o_hold;

    load_read_unit #(.WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .ld_req(ld_req), .ld_addr(ld_addr),
        .ld_funct3(ld_funct3), .ld_busy(ld_busy), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_err(ld_err), .mem_rd_req(mem_rd_req),
        .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Reference behaviour written straight from the lane/extension rules.
    function automatic exp_t model(input logic [31:0] a, input logic [2:0] f,
                                   input logic [31:0] w);
        exp_t r;
        logic [7:0]  b;
        logic [15:0] h;
        case (a[1:0])
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        r.err = 1'b0;
        case (f)
            3'd0: r.data = {{24{b[7]}}, b};
            3'd4: r.data = {24'h0, b};
            3'd1: r.data = {{16{h[15]}}, h};
            3'd5: r.data = {16'h0, h};
            3'd2: r.data = w;
            default: begin r.data = 32'h0; r.err = 1'b1; end
        endcase
        if (((f == 3'd1) || (f == 3'd5)) && a[0]) r.err = 1'b1;
        if ((f == 3'd2) && (a[1:0] != 2'b00)) r.err = 1'b1;
        if (r.err) r.data = 32'h0;
        return r;
    endfunction

    // Present one load from IDLE and act as memory: ack in request cycle
    // wait_n+1 (never if wait_n<0). Optionally ack again in the valid cycle.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3,
                            input int wait_n, input logic [31:0] word,
                            input bit late_ack);
        o_lat = -1; o_req = 0; o_raddr = '0; o_d = '0; o_e = 1'b0; o_hold = 1'b1;
        ld_req = 1'b1; ld_addr = addr; ld_funct3 = f3;
        @(posedge clk); #1;
        ld_req = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (mem_rd_req === 1'b1) begin
                if (o_req == 0) o_raddr = mem_rd_addr;
                else if (mem_rd_addr !== o_raddr) o_hold = 1'b0;
                o_req++;
            end
            if (ld_valid === 1'b1) begin
                o_lat = k; o_d = ld_data; o_e = ld_err;
                mem_rd_ack = late_ack; mem_rd_data = word;
                break;
            end
            if (mem_rd_req === 1'b1 && wait_n >= 0 && o_req == wait_n + 1) begin
                mem_rd_ack = 1'b1; mem_rd_data = word;
            end else begin
                mem_rd_ack = 1'b0; mem_rd_data = 32'hA5A5_5A5A;
            end
            @(posedge clk); #1;
        end
        if (o_lat < 0) mem_rd_ack = 1'b0;
        @(posedge clk); #1;
        mem_rd_ack = 1'b0;
        o_va = ld_valid; o_ba = ld_busy;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_rd_ack = 1'b1; mem_rd_data = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({ld_valid, ld_err, mem_rd_req, ld_busy} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0000", {ld_valid, ld_err, mem_rd_req, ld_busy}); end
        checks++; if (ld_data !== 32'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=00000000", ld_data); end
        checks++; if (mem_rd_addr !== 32'h0) begin
            failures++; $display("FAIL reset_addr got=%h exp=00000000", mem_rd_addr); end
        mem_rd_ack = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_basic();
        sb.push_back('{32'hDEADBEEF, 1'b0});
        run_load(32'h10, 3'd2, 0, 32'hDEADBEEF, 1'b0);
        ex = sb.pop_front();
        checks++; if (o_raddr !== 32'h10) begin failures++; $display("FAIL lw_addr got=%h exp=00000010", o_raddr); end
        checks++; if (o_lat !== 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", o_lat); end
        checks++; if (o_d !== ex.data) begin failures++; $display("FAIL lw_data got=%h exp=%h", o_d, ex.data); end
        checks++; if (o_e !== ex.err) begin failures++; $display("FAIL lw_err got=%b exp=%b", o_e, ex.err); end
        checks++; if ({o_va, o_ba} !== 2'b00) begin failures++; $display("FAIL lw_after got=%b exp=00", {o_va, o_ba}); end
    endtask

    task automatic test_byte();
        sb.push_back('{32'hFFFFFF80, 1'b0});
        run_load(32'h13, 3'd0, 0, 32'h80FF0000, 1'b0);
        ex = sb.pop_front();
        checks++; if (o_d !== ex.data) begin failures++; $display("FAIL lb_data got=%h exp=%h", o_d, ex.data); end
        checks++; if (o_raddr !== 32'h10) begin failures++; $display("FAIL lb_addr got=%h exp=00000010", o_raddr); end
        sb.push_back('{32'h00000080, 1'b0});
        run_load(32'h13, 3'd4, 0, 32'h80FF0000, 1'b0);
        ex = sb.pop_front();
        checks++; if (o_d !== ex.data) begin failures++; $display("FAIL lbu_data got=%h exp=%h", o_d, ex.data); end
        checks++; if (o_raddr !== 32'h10) begin failures++; $display("FAIL lbu_addr got=%h exp=00000010", o_raddr); end
    endtask

    task automatic test_half_wait();
        sb.push_back('{32'hFFFF8001, 1'b0});
        run_load(32'h2, 3'd1, 3, 32'h80011234, 1'b0);
        ex = sb.pop_front();
        checks++; if (o_d !== ex.data) begin failures++; $display("FAIL lh_data got=%h exp=%h", o_d, ex.data); end
        checks++; if (o_lat !== 5) begin failures++; $display("FAIL lh_latency got=%0d exp=5", o_lat); end
        checks++; if (o_hold !== 1'b1) begin failures++; $display("FAIL lh_addr_hold got=%b exp=1", o_hold); end
        sb.push_back('{32'h00008001, 1'b0});
        run_load(32'h2, 3'd5, 3, 32'h80011234, 1'b0);
        ex = sb.pop_front();
        checks++; if (o_d !== ex.data) begin failures++; $display("FAIL lhu_data got=%h exp=%h", o_d, ex.data); end
    endtask

    task automatic test_errors();
        sb.push_back('{32'h0, 1'b1});
        run_load(32'h6, 3'd2, 0, 32'h12345678, 1'b0);
        ex = sb.pop_front();
        checks++; if ({o_e, o_d} !== {ex.err, ex.data}) begin failures++; $display("FAIL misalign_result got=%b/%h exp=%b/%h", o_e, o_d, ex.err, ex.data); end
        checks++; if (o_lat !== 1) begin failures++; $display("FAIL misalign_latency got=%0d exp=1", o_lat); end
        checks++; if (o_req !== 0) begin failures++; $display("FAIL misalign_req got=%0d exp=0", o_req); end
        sb.push_back('{32'h0, 1'b1});
        run_load(32'h0, 3'd3, 0, 32'h12345678, 1'b0);
        ex = sb.pop_front();
        checks++; if ({o_e, o_d} !== {ex.err, ex.data}) begin failures++; $display("FAIL illegal_result got=%b/%h exp=%b/%h", o_e, o_d, ex.err, ex.data); end
        checks++; if (o_lat !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", o_lat); end
        checks++; if (o_req !== 0) begin failures++; $display("FAIL illegal_req got=%0d exp=0", o_req); end
    endtask

    task automatic test_timeout();
        sb.push_back('{32'h0, 1'b1});
        run_load(32'h20, 3'd2, -1, 32'hCAFEF00D, 1'b1);
        ex = sb.pop_front();
        checks++; if (o_req !== 16) begin failures++; $display("FAIL to_req_cycles got=%0d exp=16", o_req); end
        checks++; if (o_lat !== 17) begin failures++; $display("FAIL to_latency got=%0d exp=17", o_lat); end
        checks++; if ({o_e, o_d} !== {ex.err, ex.data}) begin failures++; $display("FAIL to_result got=%b/%h exp=%b/%h", o_e, o_d, ex.err, ex.data); end
        checks++; if ({o_va, o_ba, ld_err, ld_data} !== {3'b001, 32'h0}) begin
            failures++; $display("FAIL to_late_ack got=%b%b%b/%h exp=001/00000000", o_va, o_ba, ld_err, ld_data); end
        sb.push_back('{32'hCAFEF00D, 1'b0});
        run_load(32'h20, 3'd2, 15, 32'hCAFEF00D, 1'b0);
        ex = sb.pop_front();
        checks++; if ({o_e, o_d} !== {ex.err, ex.data}) begin failures++; $display("FAIL ack16_result got=%b/%h exp=%b/%h", o_e, o_d, ex.err, ex.data); end
        checks++; if (o_lat !== 17) begin failures++; $display("FAIL ack16_latency got=%0d exp=17", o_lat); end
    endtask

    task automatic test_back_to_back();
        int valids;
        logic addr_ok;
        logic [31:0] got;
        valids = 0; addr_ok = 1'b1; got = '0;
        sb.push_back('{32'h11223344, 1'b0});
        ld_req = 1'b1; ld_addr = 32'h40; ld_funct3 = 3'd2;
        @(posedge clk); #1;
        ld_addr = 32'h51; ld_funct3 = 3'd0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) ld_req = 1'b0;
            if (mem_rd_req === 1'b1 && mem_rd_addr !== 32'h40) addr_ok = 1'b0;
            if (ld_valid === 1'b1) begin valids++; got = ld_data; end
            mem_rd_ack = (mem_rd_req === 1'b1 && k == 3);
            mem_rd_data = (k == 3) ? 32'h11223344 : 32'h0BAD0BAD;
            @(posedge clk); #1;
        end
        mem_rd_ack = 1'b0;
        ex = sb.pop_front();
        checks++; if (valids !== 1) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=1", valids); end
        checks++; if (got !== ex.data) begin failures++; $display("FAIL b2b_data got=%h exp=%h", got, ex.data); end
        checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL b2b_addr got=%b exp=1", addr_ok); end
    endtask

    task automatic test_reset_abort();
        int valids;
        logic req_seen;
        valids = 0; req_seen = 1'b0;
        ld_req = 1'b1; ld_addr = 32'h30; ld_funct3 = 3'd2;
        @(posedge clk); #1;
        ld_req = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_rd_req !== 1'b1) begin failures++; $display("FAIL abort_pre_req got=%b exp=1", mem_rd_req); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if ({mem_rd_req, ld_busy, ld_valid, ld_err} !== 4'b0000) begin
            failures++; $display("FAIL abort_ctrl got=%b exp=0000", {mem_rd_req, ld_busy, ld_valid, ld_err}); end
        checks++; if (ld_data !== 32'h0) begin failures++; $display("FAIL abort_data got=%h exp=00000000", ld_data); end
        mem_rd_ack = 1'b1; mem_rd_data = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ld_valid === 1'b1) valids++;
            if (mem_rd_req === 1'b1) req_seen = 1'b1;
        end
        mem_rd_ack = 1'b0;
        checks++; if (valids !== 0) begin failures++; $display("FAIL abort_valid got=%0d exp=0", valids); end
        checks++; if (req_seen !== 1'b0) begin failures++; $display("FAIL abort_req got=%b exp=0", req_seen); end
    endtask

    task automatic test_random();
        logic [31:0] a, w;
        logic [2:0]  f;
        int wn;
        for (int i = 0; i < 10; i++) begin
            a = $urandom_range(0, 255);
            f = 3'($urandom_range(0, 7));
            w = $urandom;
            wn = $urandom_range(0, 3);
            sb.push_back(model(a, f, w));
            run_load(a, f, wn, w, 1'b0);
            ex = sb.pop_front();
            checks++; if ({o_e, o_d} !== {ex.err, ex.data}) begin
                failures++; $display("FAIL rand_result a=%h f=%0d got=%b/%h exp=%b/%h", a, f, o_e, o_d, ex.err, ex.data); end
            checks++; if (o_lat !== (ex.err ? 1 : wn + 2)) begin
                failures++; $display("FAIL rand_latency a=%h f=%0d got=%0d exp=%0d", a, f, o_lat, ex.err ? 1 : wn + 2); end
            if (!ex.err) begin
                checks++; if (o_raddr !== {a[31:2], 2'b00}) begin
                    failures++; $display("FAIL rand_addr got=%h exp=%h", o_raddr, {a[31:2], 2'b00}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw_basic();
        test_byte();
        test_half_wait();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_read_unit.md
Name: load_read_unit

Overview:
Read-side counterpart to the datapath register/store path. It accepts a load request from the single-cycle core and issues a word-aligned read to data memory with a req/ack handshake. It then extracts and sign- or zero-extends the addressed byte, halfword or word, and holds the result in an output register. It sits between the core's load path and the data memory read port, and flags misaligned, illegal and timed-out loads.

Parameters:
WIDTH, 32, data width; fixed at 32 for byte/halfword lane extraction.
ADDR_WIDTH, 32, byte address width.
TIMEOUT, 16, maximum cycles mem_rd_req may stay high without ack before the load is aborted with an error; must be at least 1.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous, active-low reset; sampled on rising clk.
ld_req  input  1  load request; captured only while idle.
ld_addr  input  ADDR_WIDTH  byte address of load.
ld_funct3  input  3  load type: 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU; 3, 6 and 7 are illegal.
ld_busy  output  1  high whenever state is not IDLE.
ld_valid  output  1  one-cycle pulse; ld_data and ld_err are valid.
ld_data  output  WIDTH  extended load result, registered.
ld_err  output  1  misaligned, illegal or timeout; qualified by ld_valid, held with ld_data.
mem_rd_req  output  1  memory read request, registered.
mem_rd_addr  output  ADDR_WIDTH  word-aligned address, {ld_addr[ADDR_WIDTH-1:2],2'b00}.
mem_rd_ack  input  1  memory read acknowledge; mem_rd_data valid when high.
mem_rd_data  input  WIDTH  memory read word.

Behaviour:
- Reset (rst==0 at a rising edge): state IDLE and timeout counter 0. All outputs go to 0: ld_valid, ld_data, ld_err, mem_rd_req, mem_rd_addr. ld_busy is 0 because state is IDLE.
- Reset mid-operation aborts the load. mem_rd_req is low from the next cycle, no ld_valid pulse is produced, and any later ack is ignored.
- States: IDLE, REQ, DONE.
- IDLE, on ld_req=1 at an edge: latch ld_addr[1:0] and ld_funct3, then check the request.
  - Illegal funct3, or a misaligned address (LH/LHU with addr[0]=1; LW with addr[1:0]!=0): go to DONE, load ld_data=0 and ld_err=1. No memory request is issued.
  - Otherwise: go to REQ, set mem_rd_req=1, load mem_rd_addr and clear the counter.
- REQ:
  - mem_rd_req and mem_rd_addr are held stable.
  - ack=1 at an edge: capture the extracted data, set ld_err=0, drop mem_rd_req and go to DONE.
  - No ack at an edge: the counter increments. When the counter reaches TIMEOUT-1 with no ack, go to DONE with ld_data=0, ld_err=1 and mem_rd_req dropped.
  - Ack on that same edge wins over timeout.
- DONE: ld_valid=1 for exactly one cycle, then return to IDLE. ld_data and ld_err hold until the next completion or reset.
- Latency, capture edge to ld_valid: 2 cycles with zero-wait ack (req high in cycle 1, ack sampled at the end of cycle 1). Each memory wait cycle adds 1. Misaligned or illegal loads take 1 cycle.
- Extraction uses lane = addr[1:0].
  - LB/LBU take byte mem_rd_data[8*lane+7 : 8*lane].
  - LH/LHU take halfword [16*addr[1]+15 : 16*addr[1]].
  - LW takes the full word.
  - LB/LH sign-extend to WIDTH; LBU/LHU zero-extend.
- ld_req while busy (REQ or DONE) is ignored and not queued; it must be re-presented in IDLE.
- mem_rd_ack outside REQ is ignored.
- ld_busy is combinational from state.

Test Plan:
1. LW addr 0x10, ack in first req cycle with data 0xDEADBEEF -> mem_rd_addr 0x10; ld_valid exactly 2 cycles after capture; ld_data 0xDEADBEEF; ld_err 0; ld_busy low the cycle after.
2. LB addr 0x13, data 0x80FF0000 -> ld_data 0xFFFFFF80. LBU at the same address and data -> 0x00000080. mem_rd_addr is 0x10 for both.
3. LH addr 0x2, data 0x80011234, ack after 3 wait cycles -> ld_data 0xFFFF8001, valid 5 cycles after capture. LHU at the same address and data -> 0x00008001.
4. LW addr 0x6, and separately funct3=3 at addr 0x0 -> ld_valid 1 cycle after capture with ld_err 1 and ld_data 0; mem_rd_req never asserted.
5. LW addr 0x20, no ack -> mem_rd_req high for 16 cycles, then ld_valid with ld_err 1 and ld_data 0. An ack one cycle later is ignored. Ack arriving on the 16th cycle -> success with data and no error.
6. LW in REQ, then rst=0 for one edge -> mem_rd_req 0 and ld_busy 0 next cycle; no ld_valid. A ld_req pulsed during REQ of another load is dropped, giving exactly one ld_valid.
